vector_lane_sequencer: RTL and testbench
========================================

# vector_lane_sequencer

Multi-cycle sequencer that executes 128-bit vector ALU operations in the Execute stage by time-multiplexing one shared 32-bit lane ALU across the four 32-bit lanes. It sits between the Execute-stage operand/forwarding muxes and the scalar ALU. It latches the selected operands, issues one lane per cycle to the ALU, and assembles the 128-bit result for `ALU_result_bus_E`. While a vector operation is in flight, it stalls the pipeline. Scalar operations take a single lane pass.

## Interface
Parameters:
- `LANES`, 4, number of 32-bit lanes per vector register
- `LANE_WIDTH`, 32, width of one lane and of the shared ALU
- `OP_WIDTH`, 4, width of the ALU opcode (matches `ALU_op_E`)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `start_E`  in  1  operation presented by Execute this cycle
- `vector_E`  in  1  1 = vector op (LANES passes); 0 = scalar op (lane 0 only)
- `flush_E`  in  1  abort the current or presented operation
- `ALU_op_E`  in  OP_WIDTH  opcode for all lanes of the operation
- `operand_0_E`  in  LANES*LANE_WIDTH  first operand, after forwarding muxes
- `operand_1_E`  in  LANES*LANE_WIDTH  second operand, after forwarding and immediate muxes
- `lane_result`  in  LANE_WIDTH  combinational result from the shared ALU
- `lane_a`, `lane_b`  out  LANE_WIDTH  operand slices driven to the shared ALU
- `lane_ALU_op`  out  OP_WIDTH  latched opcode driven to the shared ALU
- `lane_index`  out  2  lane currently issued
- `busy_E`  out  1  sequencer not idle
- `stall_E`  out  1  freeze IF/ID/EX pipeline registers
- `result_valid_E`  out  1  one-cycle pulse; `ALU_result_bus_E` is final
- `ALU_result_bus_E`  out  LANES*LANE_WIDTH  assembled result

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On `start_E` with `flush_E`=0: latch both operands, `ALU_op_E` and `vector_E`; set lane=0; clear the result register; go to RUN.
- RUN:
  - `lane_a`/`lane_b` = latched operand slice `[lane*32 +: 32]`.
  - Each edge writes `lane_result` into result slice `[lane*32 +: 32]`.
  - If lane = last, go to DONE; otherwise lane+1. Last = LANES-1 for vector ops, 0 for scalar ops.
- DONE:
  - `result_valid_E`=1.
  - `start_E` in DONE is accepted exactly as in IDLE (back-to-back, goes straight to RUN). Otherwise go to IDLE.
- Scalar op: result lanes 1..3 read 0.
- `start_E` during RUN is ignored; upstream holds the op because `stall_E` is high.
- `flush_E` in any state: go to IDLE next edge; the pending op is dropped and no `result_valid_E` is produced. Flush beats a simultaneous `start_E`.
- Outputs in IDLE and DONE: `lane_a`=`lane_b`=0, `lane_index`=0; `lane_ALU_op` keeps its last latched value.
- `busy_E` = (state != IDLE).
- `stall_E` = (state == RUN) | (start_E & state == IDLE & !flush_E). It also asserts for a start accepted in DONE.
- No lane carries between lanes; the ALU is purely lane-local.

## Timing
- Reset, any cycle: state=IDLE; every output 0, including `ALU_result_bus_E` and `lane_ALU_op`.
- Reset mid-RUN discards the operation immediately (asynchronous).
- Vector latency: start accepted at edge N; lanes 0..3 are issued in cycles N+1..N+4; `result_valid_E` is high in cycle N+5.
- Scalar latency: `result_valid_E` is high in cycle N+2.
- `ALU_result_bus_E` holds its value after DONE until the next accepted start clears it.
- Back-to-back throughput: one vector op per 5 cycles; one scalar op per 2 cycles.

## Structure
- Package `vector_seq_pkg`:
  - state enum `vseq_state_t` {IDLE, RUN, DONE}
  - localparams `LANES`, `LANE_WIDTH`, `VEC_WIDTH` = LANES*LANE_WIDTH
  - `LANE_IDX_W` = $clog2(LANES)
- Sub-module `vector_lane_select`: combinational slice selector for lane_index → lane_a/lane_b. The result-slice write-back stays in the top module.
- The shared 32-bit ALU is external and is not instantiated here.

## Test plan
Bench ALU model: op 4'b0000 = add.
- Reset asserted mid-RUN → all outputs 0 immediately; state IDLE after release; no `result_valid_E`.
- Vector add:
  - Stimulus: `operand_0_E` = `operand_1_E` = 128'h11112222333344445555666677778888.
  - Required: `lane_index` 0,1,2,3 in cycles N+1..N+4; `stall_E` high in cycles N..N+4; `result_valid_E` in N+5; result = 128'h2222444466668888AAAACCCCEEEF1110.
- Scalar add:
  - Stimulus: `vector_E`=0, lane-0 operands 5 and 7.
  - Required: `result_valid_E` in N+2; result = 128'h0000…000C.
- Back-to-back: second vector start held high through DONE → accepted there; second `result_valid_E` exactly 5 cycles after the first.
- Flush at lane 2 of a vector op → IDLE next cycle; no `result_valid_E`; `busy_E`=0.
- `start_E` and `flush_E` together in IDLE → nothing accepted; `busy_E` stays 0.

Source files
------------

// File: rtl/vector_seq_pkg.sv
// Shared types and sizes for the vector lane sequencer.
package vector_seq_pkg;

  localparam int unsigned LANES      = 4;
  localparam int unsigned LANE_WIDTH = 32;
  localparam int unsigned OP_WIDTH   = 4;
  localparam int unsigned VEC_WIDTH  = LANES * LANE_WIDTH;
  localparam int unsigned LANE_IDX_W = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } vseq_state_t;

endpackage

// File: rtl/vector_lane_select.sv
// Picks one lane slice of each latched operand for the shared lane ALU.
module vector_lane_select #(
  parameter int unsigned LANES      = vector_seq_pkg::LANES,
  parameter int unsigned LANE_WIDTH = vector_seq_pkg::LANE_WIDTH
) (
  input  logic                          i_en,
  input  logic [$clog2(LANES)-1:0]      i_lane,
  input  logic [LANES*LANE_WIDTH-1:0]   i_op0,
  input  logic [LANES*LANE_WIDTH-1:0]   i_op1,
  output logic [LANE_WIDTH-1:0]         o_a,
  output logic [LANE_WIDTH-1:0]         o_b
);

  localparam int unsigned LANE_IDX_W = $clog2(LANES);

  // Slice mux; outputs are zero whenever no lane is being issued.
  always_comb begin
    o_a = '0;
    o_b = '0;
    if (i_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (i_lane == LANE_IDX_W'(l)) begin
          o_a = i_op0[l*LANE_WIDTH +: LANE_WIDTH];
          o_b = i_op1[l*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/vector_lane_sequencer.sv
// Time-multiplexes one shared lane ALU across the lanes of a vector op and
// assembles the full-width result; stalls the pipeline while in flight.
module vector_lane_sequencer #(
  parameter int unsigned LANES      = vector_seq_pkg::LANES,
  parameter int unsigned LANE_WIDTH = vector_seq_pkg::LANE_WIDTH,
  parameter int unsigned OP_WIDTH   = vector_seq_pkg::OP_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_E,
  input  logic                          vector_E,
  input  logic                          flush_E,
  input  logic [OP_WIDTH-1:0]           ALU_op_E,
  input  logic [LANES*LANE_WIDTH-1:0]   operand_0_E,
  input  logic [LANES*LANE_WIDTH-1:0]   operand_1_E,
  input  logic [LANE_WIDTH-1:0]         lane_result,
  output logic [LANE_WIDTH-1:0]         lane_a,
  output logic [LANE_WIDTH-1:0]         lane_b,
  output logic [OP_WIDTH-1:0]           lane_ALU_op,
  output logic [$clog2(LANES)-1:0]      lane_index,
  output logic                          busy_E,
  output logic                          stall_E,
  output logic                          result_valid_E,
  output logic [LANES*LANE_WIDTH-1:0]   ALU_result_bus_E
);

  import vector_seq_pkg::*;

  localparam int unsigned VEC_W  = LANES * LANE_WIDTH;
  localparam int unsigned LIDX_W = $clog2(LANES);

  vseq_state_t        r_state;
  vseq_state_t        w_state_nxt;
  logic [LIDX_W-1:0]  r_lane;
  logic [LIDX_W-1:0]  w_lane_nxt;
  logic [LIDX_W-1:0]  w_last;
  logic               w_accept;
  logic               r_vector;
  logic [OP_WIDTH-1:0] r_op;
  logic [VEC_W-1:0]   r_op0;
  logic [VEC_W-1:0]   r_op1;
  logic [VEC_W-1:0]   r_result;
  logic               r_busy;
  logic               r_valid;
  logic               w_run;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_lane  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lane  <= w_lane_nxt;
    end
  end

  // Next-state and lane counter; flush always wins and returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_lane_nxt  = r_lane;
    w_accept    = 1'b0;
    w_last      = r_vector ? LIDX_W'(LANES - 1) : '0;
    case (r_state)
      IDLE, DONE: begin
        w_state_nxt = IDLE;
        w_lane_nxt  = '0;
        if (start_E && !flush_E) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (flush_E) begin
          w_state_nxt = IDLE;
          w_lane_nxt  = '0;
        end else if (r_lane == w_last) begin
          w_state_nxt = DONE;
          w_lane_nxt  = '0;
        end else begin
          w_lane_nxt  = r_lane + LIDX_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_lane_nxt  = '0;
      end
    endcase
  end

  // Operand/opcode latch, per-lane result write-back and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vector <= 1'b0;
      r_op     <= '0;
      r_op0    <= '0;
      r_op1    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_vector <= vector_E;
        r_op     <= ALU_op_E;
        r_op0    <= operand_0_E;
        r_op1    <= operand_1_E;
        r_result <= '0;
      end else if (w_run && !flush_E) begin
        for (int l = 0; l < LANES; l++) begin
          if (r_lane == LIDX_W'(l)) begin
            r_result[l*LANE_WIDTH +: LANE_WIDTH] <= lane_result;
          end
        end
      end
      r_busy  <= (w_state_nxt != IDLE);
      r_valid <= (w_state_nxt == DONE);
    end
  end

  assign w_run = (r_state == RUN);

  vector_lane_select #(
    .LANES      (LANES),
    .LANE_WIDTH (LANE_WIDTH)
  ) u_lane_select (
    .i_en   (w_run),
    .i_lane (r_lane),
    .i_op0  (r_op0),
    .i_op1  (r_op1),
    .o_a    (lane_a),
    .o_b    (lane_b)
  );

  assign lane_ALU_op      = r_op;
  assign lane_index       = r_lane;
  assign busy_E           = r_busy;
  assign result_valid_E   = r_valid;
  assign ALU_result_bus_E = r_result;
  // Stall covers the issue cycles plus the cycle a start is accepted.
  assign stall_E          = !rst && (w_run || w_accept);

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Directed bench for vector_lane_sequencer with a simple add/xor lane ALU.
module tb_vector_lane_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_E;
  logic         vector_E;
  logic         flush_E;
  logic [3:0]   ALU_op_E;
  logic [127:0] operand_0_E;
  logic [127:0] operand_1_E;
  logic [31:0]  lane_result;
  logic [31:0]  lane_a;
  logic [31:0]  lane_b;
  logic [3:0]   lane_ALU_op;
  logic [1:0]   lane_index;
  logic         busy_E;
  logic         stall_E;
  logic         result_valid_E;
  logic [127:0] ALU_result_bus_E;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] va;
  logic [127:0] vb0;
  logic [127:0] vb1;

  vector_lane_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .start_E          (start_E),
    .vector_E         (vector_E),
    .flush_E          (flush_E),
    .ALU_op_E         (ALU_op_E),
    .operand_0_E      (operand_0_E),
    .operand_1_E      (operand_1_E),
    .lane_result      (lane_result),
    .lane_a           (lane_a),
    .lane_b           (lane_b),
    .lane_ALU_op      (lane_ALU_op),
    .lane_index       (lane_index),
    .busy_E           (busy_E),
    .stall_E          (stall_E),
    .result_valid_E   (result_valid_E),
    .ALU_result_bus_E (ALU_result_bus_E)
  );

  always #5 clk = ~clk;

  // Lane ALU model: op 0 = add, op 1 = xor.
  assign lane_result = (lane_ALU_op == 4'h1) ? (lane_a ^ lane_b) : (lane_a + lane_b);

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_busy"},  128'(busy_E), 128'(0));
    check_eq({tag, "_stall"}, 128'(stall_E), 128'(0));
    check_eq({tag, "_valid"}, 128'(result_valid_E), 128'(0));
    check_eq({tag, "_lidx"},  128'(lane_index), 128'(0));
    check_eq({tag, "_la"},    128'(lane_a), 128'(0));
    check_eq({tag, "_lb"},    128'(lane_b), 128'(0));
  endtask

  initial begin
    va  = 128'h11112222333344445555666677778888;
    vb0 = 128'h00000001000000020000000300000004;
    vb1 = 128'h10000000200000003000000040000000;
    rst = 1'b1;
    start_E = 1'b0; vector_E = 1'b0; flush_E = 1'b0; ALU_op_E = 4'h0;
    operand_0_E = '0; operand_1_E = '0;
    #2;
    check_quiet("rst0");
    check_eq("rst0_op", 128'(lane_ALU_op), 128'(0));
    check_eq("rst0_res", ALU_result_bus_E, 128'(0));
    tick; tick;
    rst = 1'b0;
    tick;

    // Vector add
    start_E = 1'b1; vector_E = 1'b1; ALU_op_E = 4'h0;
    operand_0_E = va; operand_1_E = va;
    #1;
    check_eq("vadd_N_stall", 128'(stall_E), 128'(1));
    check_eq("vadd_N_busy",  128'(busy_E), 128'(0));
    tick;
    start_E = 1'b0;
    for (int l = 0; l < 4; l++) begin
      if (l > 0) tick;
      #1;
      check_eq("vadd_lidx",  128'(lane_index), 128'(l));
      check_eq("vadd_stall", 128'(stall_E), 128'(1));
      check_eq("vadd_busy",  128'(busy_E), 128'(1));
      check_eq("vadd_la",    128'(lane_a), 128'(va[l*32 +: 32]));
      check_eq("vadd_valid", 128'(result_valid_E), 128'(0));
    end
    tick; #1;
    check_eq("vadd_done_valid", 128'(result_valid_E), 128'(1));
    check_eq("vadd_done_stall", 128'(stall_E), 128'(0));
    check_eq("vadd_done_la",    128'(lane_a), 128'(0));
    check_eq("vadd_result", ALU_result_bus_E, 128'h2222444466668888AAAACCCCEEEF1110);
    tick; #1;
    check_quiet("vadd_after");
    check_eq("vadd_hold", ALU_result_bus_E, 128'h2222444466668888AAAACCCCEEEF1110);

    // Scalar add with junk in upper lanes
    tick;
    start_E = 1'b1; vector_E = 1'b0;
    operand_0_E = 128'hDEADBEEF_CAFEF00D_12345678_00000005;
    operand_1_E = 128'h0BADF00D_FFFFFFFF_87654321_00000007;
    #1;
    check_eq("sadd_N_stall", 128'(stall_E), 128'(1));
    tick;
    start_E = 1'b0;
    #1;
    check_eq("sadd_lidx",  128'(lane_index), 128'(0));
    check_eq("sadd_stall", 128'(stall_E), 128'(1));
    check_eq("sadd_valid1", 128'(result_valid_E), 128'(0));
    tick; #1;
    check_eq("sadd_valid2", 128'(result_valid_E), 128'(1));
    check_eq("sadd_result", ALU_result_bus_E, 128'h0000000000000000000000000000000C);
    tick; #1;
    check_quiet("sadd_after");

    // Back-to-back: start held through RUN and accepted in DONE
    tick;
    start_E = 1'b1; vector_E = 1'b1; ALU_op_E = 4'h0;
    operand_0_E = va; operand_1_E = va;
    tick;
    operand_0_E = vb0; operand_1_E = vb1;
    tick; tick; tick;
    tick; #1;
    check_eq("b2b_valid1", 128'(result_valid_E), 128'(1));
    check_eq("b2b_res1", ALU_result_bus_E, 128'h2222444466668888AAAACCCCEEEF1110);
    check_eq("b2b_done_stall", 128'(stall_E), 128'(1));
    tick;
    start_E = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick;
      #1;
      check_eq("b2b_gap_valid", 128'(result_valid_E), 128'(0));
      check_eq("b2b_lidx", 128'(lane_index), 128'(c));
    end
    tick; #1;
    check_eq("b2b_valid2", 128'(result_valid_E), 128'(1));
    check_eq("b2b_res2", ALU_result_bus_E, 128'h10000001200000023000000340000004);
    tick; #1;
    check_quiet("b2b_after");

    // Flush at lane 2
    tick;
    start_E = 1'b1; vector_E = 1'b1;
    operand_0_E = va; operand_1_E = va;
    tick;
    start_E = 1'b0;
    tick; tick;
    flush_E = 1'b1;
    #1;
    check_eq("flush_lidx", 128'(lane_index), 128'(2));
    check_eq("flush_stall", 128'(stall_E), 128'(1));
    tick;
    flush_E = 1'b0;
    #1;
    check_quiet("flush_next");
    for (int c = 0; c < 5; c++) begin
      tick; #1;
      check_eq("flush_novalid", 128'(result_valid_E), 128'(0));
      check_eq("flush_idle",    128'(busy_E), 128'(0));
    end

    // start + flush together in IDLE
    start_E = 1'b1; flush_E = 1'b1;
    #1;
    check_eq("sf_stall", 128'(stall_E), 128'(0));
    tick;
    #1;
    check_eq("sf_busy1", 128'(busy_E), 128'(0));
    tick;
    start_E = 1'b0; flush_E = 1'b0;
    #1;
    check_quiet("sf_after");

    // Reset mid-RUN with xor op
    tick;
    start_E = 1'b1; vector_E = 1'b1; ALU_op_E = 4'h1;
    operand_0_E = 128'h0123456789ABCDEF0011223344556677;
    operand_1_E = '0;
    tick;
    start_E = 1'b0;
    tick; #1;
    check_eq("rrun_op",   128'(lane_ALU_op), 128'(1));
    check_eq("rrun_part", ALU_result_bus_E, 128'h00000000000000000000000044556677);
    rst = 1'b1;
    #1;
    check_quiet("rrun");
    check_eq("rrun_op0",  128'(lane_ALU_op), 128'(0));
    check_eq("rrun_res0", ALU_result_bus_E, 128'(0));
    tick; tick;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick; #1;
      check_eq("rrun_novalid", 128'(result_valid_E), 128'(0));
      check_eq("rrun_idle",    128'(busy_E), 128'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
